// File: rtl/csr_pkg.sv
// Shared types, CSR address map and write-data helper for the CSR access unit.
// Holds the Zicsr op encoding, the access FSM states and the RMW data function.
package csr_pkg;

  localparam int CSR_XLEN = 32;

  typedef enum logic [1:0] {
    CSR_RSVD = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } csr_state_e;

  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  function automatic logic [CSR_XLEN-1:0] csr_wdata_f(
    input csr_op_e             op,
    input logic [CSR_XLEN-1:0] old,
    input logic [CSR_XLEN-1:0] src
  );
    logic [CSR_XLEN-1:0] r;
    case (op)
      CSR_RW:  r = src;
      CSR_RS:  r = old | src;
      CSR_RC:  r = old & ~src;
      default: r = old;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle between execute, the CSR access unit and the CSR file.
// master: execute + CSR file side; slave: the access unit.
interface csr_access_unit_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic            req_src_zero;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  logic [11:0]     csr_addr;
  logic            csr_wen;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output req_valid, req_op, req_addr,
    output req_src, req_src_zero,
    output resp_ready, csr_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_illegal,
    input  csr_addr, csr_wen, csr_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    input  req_src, req_src_zero,
    input  resp_ready, csr_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_illegal,
    output csr_addr, csr_wen, csr_wdata
  );

endinterface

// File: rtl/csr_access_unit.sv
// Zicsr initiator: reads a CSR, optionally writes back RMW data, returns old value.
// Ports: clock, reset (async active-low), bus (slave modport of csr_access_unit_if).
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN     = CSR_XLEN,
  parameter bit RO_CHECK = 1'b1
) (
  input logic         clock,
  input logic         reset,
  csr_access_unit_if.slave bus
);

  csr_state_e      state_q, state_d;
  csr_op_e         op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] rdata_q;
  logic            wr_q;
  logic            illegal_q;

  csr_op_e op_in;
  logic    wr_in;
  logic    ill_in;
  logic    accept;

  assign op_in  = csr_op_e'(bus.req_op);
  assign wr_in  = (op_in == CSR_RW) ||
                  (op_in != CSR_RSVD && !bus.req_src_zero);
  assign ill_in = (op_in == CSR_RSVD) ||
                  (RO_CHECK && wr_in &&
                   bus.req_addr[11:10] == 2'b11);
  assign accept = (state_q == ST_IDLE) && bus.req_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.req_valid)
          state_d = ill_in ? ST_RESP : ST_READ;
      ST_READ:
        state_d = wr_q ? ST_WRITE : ST_RESP;
      ST_WRITE:
        state_d = ST_RESP;
      ST_RESP:
        if (bus.resp_ready) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= CSR_RSVD;
      addr_q    <= '0;
      src_q     <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= op_in;
        addr_q    <= bus.req_addr;
        src_q     <= bus.req_src;
        wr_q      <= wr_in;
        illegal_q <= ill_in;
      end
      if (state_q == ST_READ) rdata_q <= bus.csr_rdata;
    end
  end

  // addr_q only moves on accept, so csr_addr naturally
  // keeps its last value while idle.
  always_comb begin
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = '0;
    bus.resp_illegal = 1'b0;
    bus.csr_wen      = 1'b0;
    bus.csr_wdata    = '0;
    bus.csr_addr     = addr_q;
    unique case (1'b1)
      (state_q == ST_IDLE):
        bus.req_ready = 1'b1;
      (state_q == ST_WRITE): begin
        bus.csr_wen   = 1'b1;
        bus.csr_wdata = csr_wdata_f(op_q, rdata_q, src_q);
      end
      (state_q == ST_RESP): begin
        bus.resp_valid   = 1'b1;
        bus.resp_illegal = illegal_q;
        bus.resp_rdata   = illegal_q ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the machine-mode CSR file interface.
- Accepts one Zicsr operation (CSRRW/CSRRS/CSRRC and their immediate forms) from decode/execute and reads the addressed CSR.
- Performs the read-modify-write and returns the old value for rd.
- Sits between the core's execute stage and the CSR file; holds at most one request in flight.

Parameters:
- XLEN, 32, data width; matches the CSR file word width.
- RO_CHECK, 1, when 1, a write to addr[11:10]==2'b11 is flagged illegal and suppressed.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request from execute
- req_ready  out  1  unit can accept a request
- req_op  in  2  01=RW, 10=RS, 11=RC, 00=reserved
- req_addr  in  12  CSR address
- req_src  in  XLEN  rs1 value or zero-extended uimm
- req_src_zero  in  1  rs1 index / uimm field is zero
- resp_valid  out  1  result available
- resp_ready  in  1  execute consumes result
- resp_rdata  out  XLEN  old CSR value (0 when illegal)
- resp_illegal  out  1  illegal-instruction indication
- csr_addr  out  12  address to CSR file
- csr_wen  out  1  CSR file write enable, one-cycle pulse
- csr_wdata  out  XLEN  CSR write data
- csr_rdata  in  XLEN  combinational read data from CSR file

Behaviour:
- Reset (reset low, async):
  - state=IDLE
  - req_ready=1 once reset is released
  - resp_valid=0, resp_illegal=0, resp_rdata=0
  - csr_wen=0, csr_wdata=0, csr_addr=0
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/addr/src/src_zero.
  - write_needed = (op==RW) or (op!=00 and !src_zero).
  - illegal = (op==00) or (RO_CHECK and write_needed and addr[11:10]==2'b11).
  - Next state: illegal -> RESP; otherwise -> READ.
- READ: csr_addr=addr_q; csr_rdata captured into rdata_q at the clock edge. Next state: write_needed -> WRITE, else RESP.
- WRITE:
  - csr_wen=1 for exactly this cycle; csr_addr=addr_q.
  - csr_wdata: RW = src_q; RS = rdata_q | src_q; RC = rdata_q & ~src_q.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_rdata=rdata_q (0 if illegal); resp_illegal=illegal_q.
  - All resp_* outputs stay stable while resp_ready=0.
  - On resp_ready, go to IDLE; no same-cycle accept of a new request.
- req_ready=0 in every state except IDLE.
- Latency from accept edge to resp_valid:
  - 3 cycles with a write
  - 2 cycles without a write
  - 1 cycle when illegal
- csr_addr holds addr_q in all non-IDLE states and keeps its last value in IDLE.
- csr_wen and resp_valid are decoded from state, so reset drops them immediately.
- Reset mid-operation: the request is abandoned, no later write is issued, and no response is produced.
- CSRRW with rd==0 still performs the read (CSR reads are side-effect free).
- An RS/RC write of an unchanged value is still issued when src_zero=0.
- Arithmetic is plain XLEN bitwise; no width extension inside the unit (uimm is zero-extended upstream).

Decomposition:
- Shared package csr_pkg holds:
  - op enum (CSR_RW/CSR_RS/CSR_RC/CSR_RSVD) and FSM state enum
  - CSR address constants (MISA 0x301, MVENDORID 0xF11, MARCHID 0xF12, MCYCLE 0xB00/0xB80, MINSTRET 0xB02/0xB82)
  - a pure function computing write data from (op, old, src)
- No sub-module; a single module of FSM plus datapath registers.

Test Plan:
- CSRRS 0x301, src_zero=1 -> resp_valid 2 cycles after accept, rdata=0x40000010, csr_wen never asserted.
- CSRRW 0xB00, src=0x12345678 -> csr_wen pulses 1 cycle with wdata=0x12345678, resp rdata = prior mcycle low word, latency 3.
- CSRRC 0xB02, model rdata 0x000000FF, src=0x0000000F -> wdata=0x000000F0. CSRRS with src=0x100 -> wdata=0x000001FF.
- CSRRW 0xF11 -> resp_illegal=1, rdata=0, latency 1, no csr_wen. CSRRS 0xF11 with src_zero=1 -> legal, rdata=0x62656B61.
- Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, a second req_valid is not accepted. Release -> IDLE next cycle, then accept.
- Assert reset during the WRITE cycle -> csr_wen drops asynchronously, resp_valid=0, and req_ready=1 after release with no stray write.
